// File: rtl/riscv_pipe_ctrl_pkg.sv
// ============================================================================
// riscv_pipe_ctrl_pkg : shared widths, FSM encodings and stage-control
// words for the pipeline stall/flush sequencer.   Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pipe_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] PCTL_S_INIT    = 2'd0;
   localparam logic [1:0] PCTL_S_RUN     = 2'd1;
   localparam logic [1:0] PCTL_S_MEMWAIT = 2'd2;
   localparam logic [1:0] PCTL_S_DRAIN   = 2'd3;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_bubble;
      logic idex_en;
      logic idex_bubble;
      logic exmem_en;
      logic memwb_en;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_OFF = '0;
   localparam pipe_ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_bubble: 1'b0,
                                       idex_en: 1'b1, idex_bubble: 1'b0,
                                       exmem_en: 1'b1, memwb_en: 1'b1};
   localparam pipe_ctrl_t CTRL_FLUSH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_bubble: 1'b1,
                                         idex_en: 1'b1, idex_bubble: 1'b1,
                                         exmem_en: 1'b1, memwb_en: 1'b1};
   // Hold PC and IF/ID, inject one NOP into EX.
   localparam pipe_ctrl_t CTRL_HOLD_ID = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_bubble: 1'b0,
                                           idex_en: 1'b1, idex_bubble: 1'b1,
                                           exmem_en: 1'b1, memwb_en: 1'b1};
   localparam pipe_ctrl_t CTRL_FETCH_WAIT = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_bubble: 1'b1,
                                              idex_en: 1'b1, idex_bubble: 1'b0,
                                              exmem_en: 1'b1, memwb_en: 1'b1};

   function automatic logic load_use_hazard(
      input logic      ex_load,
      input reg_addr_t ex_rd,
      input reg_addr_t rs1,
      input logic      rs1_use,
      input reg_addr_t rs2,
      input logic      rs2_use
   );
      return ex_load && (ex_rd != '0) &&
             ((rs1_use && (rs1 == ex_rd)) || (rs2_use && (rs2 == ex_rd)));
   endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_sat_counter.sv
// ============================================================================
// riscv_sat_counter : saturating up-counter, async active-low reset.   Rev 1.0
// ============================================================================
`default_nettype none

module riscv_sat_counter
#(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/riscv_pipe_ctrl.sv
// ============================================================================
// riscv_pipe_ctrl : stall/flush sequencer for the 5-stage RV32I pipeline,
// with saturating stall and flush performance counters.   Rev 1.0
// ============================================================================
`default_nettype none

module riscv_pipe_ctrl
   import riscv_pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic                  i_id_rs1_use,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic                  i_id_rs2_use,
   input  logic                  i_id_serial,
   input  logic [REG_ADDR_W-1:0] i_ex_rd,
   input  logic                  i_ex_load,
   input  logic                  i_ex_br_taken,
   input  logic                  i_imem_valid,
   input  logic                  i_dmem_req,
   input  logic                  i_dmem_ack,
   output logic                  o_pc_en,
   output logic                  o_ifid_en,
   output logic                  o_ifid_bubble,
   output logic                  o_idex_en,
   output logic                  o_idex_bubble,
   output logic                  o_exmem_en,
   output logic                  o_memwb_en,
   output logic [CNT_W-1:0]      o_stall_cnt,
   output logic [CNT_W-1:0]      o_flush_cnt
);

   localparam int                 DRAIN_W    = 3;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

   logic [1:0]         state_q;
   logic [1:0]         state_d;
   logic [DRAIN_W-1:0] drain_q;
   logic [DRAIN_W-1:0] drain_d;

   pipe_ctrl_t w_ctrl;
   logic       w_dmem_wait;
   logic       w_load_use;
   logic       w_eval_run;
   logic       w_flush;
   logic       w_serial_stall;
   logic       w_stall_inc;

   assign w_dmem_wait = i_dmem_req && !i_dmem_ack;
   assign w_load_use  = load_use_hazard(i_ex_load, i_ex_rd, i_id_rs1, i_id_rs1_use,
                                        i_id_rs2, i_id_rs2_use);

   // Cycles that follow the full RUN priority: the ack cycle out of MEMWAIT,
   // and the DRAIN exit cycle where the held serializing instruction issues.
   assign w_eval_run = (state_q == PCTL_S_RUN) ||
                       ((state_q == PCTL_S_MEMWAIT) && !w_dmem_wait) ||
                       ((state_q == PCTL_S_DRAIN) && !w_dmem_wait &&
                        (i_ex_br_taken || (drain_q == '0)));

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= PCTL_S_INIT;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      if (state_q == PCTL_S_INIT) begin
         state_d = PCTL_S_RUN;
      end else if (w_eval_run) begin
         drain_d = '0;
         if (w_dmem_wait) begin
            state_d = PCTL_S_MEMWAIT;
         end else if (w_serial_stall) begin
            state_d = PCTL_S_DRAIN;
            drain_d = DRAIN_LOAD;
         end else begin
            state_d = PCTL_S_RUN;
         end
      end else if ((state_q == PCTL_S_DRAIN) && !w_dmem_wait) begin
         drain_d = drain_q - DRAIN_W'(1);
      end
   end

   // Hazard detection and stage-control decode.
   always_comb begin
      w_ctrl         = CTRL_OFF;
      w_flush        = 1'b0;
      w_serial_stall = 1'b0;
      if (w_eval_run) begin
         if (w_dmem_wait) begin
            w_ctrl = CTRL_OFF;
         end else if (i_ex_br_taken) begin
            w_ctrl  = CTRL_FLUSH;
            w_flush = 1'b1;
         end else if (w_load_use) begin
            w_ctrl = CTRL_HOLD_ID;
         end else if (i_id_serial && (state_q != PCTL_S_DRAIN)) begin
            w_ctrl         = CTRL_HOLD_ID;
            w_serial_stall = 1'b1;
         end else if (!i_imem_valid) begin
            w_ctrl = CTRL_FETCH_WAIT;
         end else begin
            w_ctrl = CTRL_RUN;
         end
      end else if ((state_q == PCTL_S_DRAIN) && !w_dmem_wait) begin
         w_ctrl = CTRL_HOLD_ID;
      end
   end

   assign o_pc_en       = w_ctrl.pc_en;
   assign o_ifid_en     = w_ctrl.ifid_en;
   assign o_ifid_bubble = w_ctrl.ifid_bubble;
   assign o_idex_en     = w_ctrl.idex_en;
   assign o_idex_bubble = w_ctrl.idex_bubble;
   assign o_exmem_en    = w_ctrl.exmem_en;
   assign o_memwb_en    = w_ctrl.memwb_en;

   assign w_stall_inc = !w_ctrl.pc_en && (state_q != PCTL_S_INIT);

   riscv_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_inc  (w_stall_inc),
      .o_cnt  (o_stall_cnt)
   );

   riscv_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_inc  (w_flush),
      .o_cnt  (o_flush_cnt)
   );

endmodule

`default_nettype wire
